// File: rtl/divider_32x16_seq_if.sv
// Handshake and operand/result bundle for the sequential 32/16 divider.
interface divider_32x16_seq_if #(
   parameter int DW_N = 32,
   parameter int DW_D = 16
);
   logic            start;
   logic [DW_N-1:0] dividend;
   logic [DW_D-1:0] divisor;
   logic            busy;
   logic            done;
   logic [DW_N-1:0] quotient;
   logic [DW_D-1:0] remainder;
   logic            div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divider_32x16_seq.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// Zero divisor short-circuits to an all-ones quotient with div_by_zero set.
module divider_32x16_seq #(
   parameter int DW_N = 32,
   parameter int DW_D = 16
) (
   input logic              clk,
   input logic              rst_n,
   divider_32x16_seq_if.slave bus
);
   localparam int CW = $clog2(DW_N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   logic [DW_N-1:0] work_r;
   logic [DW_D-1:0] divisor_r;
   logic [DW_D-1:0] pr_r;
   logic [CW-1:0]   cnt_r;
   logic            busy_r;
   logic            done_r;
   logic            dbz_r;
   logic [DW_N-1:0] quotient_r;
   logic [DW_D-1:0] remainder_r;

   logic [DW_D:0]   pr_shift_s;
   logic [DW_D:0]   pr_sub_s;
   logic            ge_s;
   logic [DW_D-1:0] pr_next_s;
   logic [DW_N-1:0] work_next_s;

   // One restoring step; a clear borrow bit of the trial subtract means pr >= divisor.
   always_comb begin
      pr_shift_s  = {pr_r, work_r[DW_N-1]};
      pr_sub_s    = pr_shift_s - {1'b0, divisor_r};
      ge_s        = ~pr_sub_s[DW_D];
      if (ge_s) begin
         pr_next_s = pr_sub_s[DW_D-1:0];
      end else begin
         pr_next_s = pr_shift_s[DW_D-1:0];
      end
      work_next_s = {work_r[DW_N-2:0], ge_s};
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         work_r      <= {DW_N{1'b0}};
         divisor_r   <= {DW_D{1'b0}};
         pr_r        <= {DW_D{1'b0}};
         cnt_r       <= {CW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         dbz_r       <= 1'b0;
         quotient_r  <= {DW_N{1'b0}};
         remainder_r <= {DW_D{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  work_r    <= bus.dividend;
                  divisor_r <= bus.divisor;
                  busy_r    <= 1'b1;
                  if (bus.divisor != {DW_D{1'b0}}) begin
                     pr_r    <= {DW_D{1'b0}};
                     cnt_r   <= {CW{1'b0}};
                     state_r <= CALC;
                  end else begin
                     quotient_r  <= {DW_N{1'b1}};
                     remainder_r <= bus.dividend[DW_D-1:0];
                     dbz_r       <= 1'b1;
                     done_r      <= 1'b1;
                     state_r     <= DONE;
                  end
               end
            end
            CALC: begin
               pr_r   <= pr_next_s;
               work_r <= work_next_s;
               cnt_r  <= cnt_r + CW'(1'b1);
               // Results only move on the last step so they hold during CALC.
               if (cnt_r == CW'(DW_N - 1)) begin
                  quotient_r  <= work_next_s;
                  remainder_r <= pr_next_s;
                  dbz_r       <= 1'b0;
                  done_r      <= 1'b1;
                  state_r     <= DONE;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_divider_32x16_seq.sv
// Directed self-checking bench for divider_32x16_seq with hand-computed results.
module tb_divider_32x16_seq;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   divider_32x16_seq_if #(.DW_N(32), .DW_D(16)) bus ();

   divider_32x16_seq #(.DW_N(32), .DW_D(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for done (bounded), counting cycles after acceptance edge and busy-high samples.
   task automatic wait_done(output int lat, output int bcnt, output bit q_moved);
      logic [31:0] q0;
      q0      = bus.quotient;
      lat     = 0;
      bcnt    = 0;
      q_moved = 1'b0;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (bus.busy === 1'b1) bcnt++;
         if (bus.quotient !== q0) q_moved = 1'b1;
         tick();
         lat++;
      end
      if (bus.busy === 1'b1) bcnt++;
   endtask

   task automatic run_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                          input logic [31:0] exp_q, input logic [15:0] exp_r, input logic exp_z);
      int lat;
      int bcnt;
      bit q_moved;
      int exp_lat;
      exp_lat      = exp_z ? 0 : 32;
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      tick();
      bus.start    = 1'b0;
      bus.dividend = 32'hDEAD_BEEF;
      bus.divisor  = 16'h1357;
      wait_done(lat, bcnt, q_moved);
      chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_q"}, {32'd0, bus.quotient}, {32'd0, exp_q});
      chk({tag, "_r"}, {48'd0, bus.remainder}, {48'd0, exp_r});
      chk({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, exp_z});
      chk({tag, "_qhold"}, {63'd0, q_moved}, 64'd0);
      tick();
      chk({tag, "_done_fall"}, {63'd0, bus.done}, 64'd0);
      chk({tag, "_busy_fall"}, {63'd0, bus.busy}, 64'd0);
      chk({tag, "_busy_cyc"}, 64'(bcnt), 64'(exp_lat + 1));
      chk({tag, "_q_keep"}, {32'd0, bus.quotient}, {32'd0, exp_q});
   endtask

   initial begin
      int  lat;
      int  bcnt;
      bit  q_moved;
      bit  saw_done;
      n_cmp        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = 32'h0;
      bus.divisor  = 16'h0;
      tick();
      tick();
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_q", {32'd0, bus.quotient}, 64'd0);
      chk("rst_r", {48'd0, bus.remainder}, 64'd0);
      chk("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
      rst_n = 1'b1;
      tick();

      run_div("one",   32'h0000_0001, 16'h0001, 32'h0000_0001, 16'h0000, 1'b0);
      run_div("inv1",  32'h0626_0060, 16'h5678, 32'h0000_1234, 16'h0000, 1'b0);
      run_div("inv2",  32'h4000_0000, 16'h8000, 32'h0000_8000, 16'h0000, 1'b0);
      run_div("inv3",  32'h0001_FFFE, 16'h0002, 32'h0000_FFFF, 16'h0000, 1'b0);
      run_div("max",   32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, 16'h0000, 1'b0);
      run_div("rem5",  32'h0626_0065, 16'h5678, 32'h0000_1234, 16'h0005, 1'b0);
      run_div("small", 32'h0000_0003, 16'hFFFF, 32'h0000_0000, 16'h0003, 1'b0);
      run_div("dbz",   32'h0000_ABCD, 16'h0000, 32'hFFFF_FFFF, 16'hABCD, 1'b1);
      run_div("after", 32'h0000_0008, 16'h0002, 32'h0000_0004, 16'h0000, 1'b0);

      // Start pulsed while busy must be ignored.
      bus.start    = 1'b1;
      bus.dividend = 32'h0000_0064;
      bus.divisor  = 16'h000A;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      bus.start    = 1'b1;
      bus.dividend = 32'hFFFF_FFFF;
      bus.divisor  = 16'h0001;
      tick();
      bus.start = 1'b0;
      wait_done(lat, bcnt, q_moved);
      chk("ign_lat", 64'(lat + 10), 64'd32);
      chk("ign_q", {32'd0, bus.quotient}, 64'd10);
      chk("ign_r", {48'd0, bus.remainder}, 64'd0);
      tick();

      // Start held high: next accept on the first IDLE edge after DONE.
      bus.start    = 1'b1;
      bus.dividend = 32'h0000_0008;
      bus.divisor  = 16'h0002;
      tick();
      wait_done(lat, bcnt, q_moved);
      chk("hold_lat", 64'(lat), 64'd32);
      tick();
      chk("hold_idle_busy", {63'd0, bus.busy}, 64'd0);
      tick();
      chk("hold_reaccept", {63'd0, bus.busy}, 64'd1);
      bus.start = 1'b0;
      wait_done(lat, bcnt, q_moved);
      chk("hold_lat2", 64'(lat), 64'd32);
      chk("hold_q", {32'd0, bus.quotient}, 64'd4);
      tick();

      // Reset mid-operation aborts with no done pulse.
      bus.start    = 1'b1;
      bus.dividend = 32'h0000_0064;
      bus.divisor  = 16'h0003;
      tick();
      bus.start = 1'b0;
      repeat (14) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_busy", {63'd0, bus.busy}, 64'd0);
      chk("mrst_done", {63'd0, bus.done}, 64'd0);
      chk("mrst_q", {32'd0, bus.quotient}, 64'd0);
      chk("mrst_r", {48'd0, bus.remainder}, 64'd0);
      chk("mrst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
      end
      chk("mrst_quiet", {63'd0, saw_done}, 64'd0);
      run_div("fresh", 32'h0000_0007, 16'h0002, 32'h0000_0003, 16'h0001, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
